// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic generator: flit types, FSM states, LFSR taps.
// Also provides the mesh-walk helper used for sequential destination selection.
package noc_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } tg_state_t;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b10;

  localparam int LFSR_W     = 32;
  localparam int LFSR_TAP_A = 32;
  localparam int LFSR_TAP_B = 22;

  // Row-major step through the mesh: x first, carry into y, y wraps.
  function automatic logic [7:0] next_node(input logic [3:0] x, input logic [3:0] y,
                                           input int mesh_x, input int mesh_y);
    int nx;
    int ny;
    nx = int'(x) + 1;
    ny = int'(y);
    if (nx >= mesh_x) begin
      nx = 0;
      ny = ny + 1;
      if (ny >= mesh_y) ny = 0;
    end
    return {4'(ny), 4'(nx)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 32-bit Fibonacci XNOR LFSR (taps 32, 22), advancing every cycle out of reset.
// Latency: state visible the cycle after reset release; no backpressure.
module lfsr_core
  import noc_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= {state[LFSR_W-2:0], ~(state[LFSR_TAP_A-1] ^ state[LFSR_TAP_B-1])};
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// NoC packet generator: head/body/tail flits every GAP idle cycles; valid/ready held until accepted.
// Macro TRAFFIC_GEN_RAND_DEST_EN selects LFSR destinations instead of the sequential mesh walk.
module noc_traffic_gen
  import noc_tg_pkg::*;
#(
  parameter int          FLIT_W     = 32,
  parameter int          MESH_X     = 2,
  parameter int          MESH_Y     = 2,
  parameter int          SRC_X      = 0,
  parameter int          SRC_Y      = 0,
  parameter int          BODY_FLITS = 2,
  parameter int          GAP        = 100,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [15:0]       pkt_count,
  output logic              busy
);

  localparam logic [15:0] GAP_C     = 16'(GAP);
  localparam logic [7:0]  LAST_BODY = 8'(BODY_FLITS - 1);
  localparam logic [3:0]  SX        = 4'(SRC_X);
  localparam logic [3:0]  SY        = 4'(SRC_Y);

  tg_state_t         state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [15:0]       gap_cnt, ts_cnt, head_ts;
  logic [7:0]        pid, body_cnt;
  logic [3:0]        head_dx, head_dy;
  logic [FLIT_W-1:0] head_flit, body_flit, tail_flit;
  logic              xfer, load_head, load_body, load_tail, tail_done;

  lfsr_core #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .state(lfsr)
  );

  assign flit_valid = (state != ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign xfer       = flit_valid & flit_ready;

`ifdef TRAFFIC_GEN_RAND_DEST_EN
  // Power-of-two mesh: masking is the modulo; flipping x bit 0 stays in range.
  always_comb begin
    head_dx = lfsr[3:0] & 4'(MESH_X - 1);
    head_dy = lfsr[7:4] & 4'(MESH_Y - 1);
    if (head_dx == SX && head_dy == SY) head_dx[0] = ~head_dx[0];
  end
`else
  localparam logic [7:0] FIRST_DST = (SRC_X == 0 && SRC_Y == 0) ?
                                     next_node(4'd0, 4'd0, MESH_X, MESH_Y) : 8'h00;
  logic [3:0] dst_x, dst_y;
  logic [7:0] seq_nxt;

  always_comb begin
    seq_nxt = next_node(dst_x, dst_y, MESH_X, MESH_Y);
    if (seq_nxt == {SY, SX}) seq_nxt = next_node(seq_nxt[3:0], seq_nxt[7:4], MESH_X, MESH_Y);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {dst_y, dst_x} <= FIRST_DST;
    end else if (tail_done) begin
      {dst_y, dst_x} <= seq_nxt;
    end
  end

  assign head_dx = dst_x;
  assign head_dy = dst_y;
`endif

  always_comb begin
    head_flit                 = '0;
    head_flit[FLIT_W-1 -: 2]  = FT_HEAD;
    head_flit[15:12]          = head_dy;
    head_flit[11:8]           = head_dx;
    head_flit[7:0]            = pid;
    body_flit                 = FLIT_W'(lfsr);
    body_flit[FLIT_W-1 -: 2]  = FT_BODY;
    tail_flit                 = '0;
    tail_flit[FLIT_W-1 -: 2]  = FT_TAIL;
    // With no body flits the tail is built on the head-transfer edge itself.
    tail_flit[29:14]          = (state == ST_HEAD) ? ts_cnt : head_ts;
    tail_flit[7:0]            = pid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_body = 1'b0;
    load_tail = 1'b0;
    tail_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && gap_cnt == GAP_C) begin
          state_nxt = ST_HEAD;
          load_head = 1'b1;
        end
      end
      ST_HEAD: begin
        if (xfer) begin
          if (BODY_FLITS == 0) begin
            state_nxt = ST_TAIL;
            load_tail = 1'b1;
          end else begin
            state_nxt = ST_BODY;
            load_body = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          if (body_cnt == LAST_BODY) begin
            state_nxt = ST_TAIL;
            load_tail = 1'b1;
          end else begin
            load_body = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (xfer) begin
          state_nxt = ST_IDLE;
          tail_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_out  <= '0;
      pkt_count <= '0;
      pid       <= '0;
      gap_cnt   <= '0;
      ts_cnt    <= '0;
      head_ts   <= '0;
      body_cnt  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (state == ST_IDLE && enable && gap_cnt != GAP_C) gap_cnt <= gap_cnt + 16'd1;
      if (load_head) flit_out <= head_flit;
      if (load_body) flit_out <= body_flit;
      if (load_tail) flit_out <= tail_flit;
      if (state == ST_HEAD && xfer) begin
        head_ts  <= ts_cnt;
        body_cnt <= '0;
      end
      if (state == ST_BODY && xfer) body_cnt <= body_cnt + 8'd1;
      if (tail_done) begin
        pid       <= pid + 8'd1;
        pkt_count <= pkt_count + 16'd1;
        gap_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench: default generator plus a 4x2 mesh, zero-body, GAP=1 instance at node (1,1).
module tb_noc_traffic_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flit_ready = 1'b0;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic [15:0] pkt_count;
  logic        busy;

  logic        enable2 = 1'b0;
  logic        ready2 = 1'b1;
  logic [31:0] flit_out2;
  logic        flit_valid2;
  logic [15:0] pkt_count2;
  logic        busy2;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] m_lfsr, m_prev;
  logic [15:0] cyc;

  always #5 clk = ~clk;

  noc_traffic_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .pkt_count(pkt_count), .busy(busy)
  );

  noc_traffic_gen #(
    .FLIT_W(32), .MESH_X(4), .MESH_Y(2), .SRC_X(1), .SRC_Y(1),
    .BODY_FLITS(0), .GAP(1), .SEED(32'h1234_5678)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .flit_out(flit_out2), .flit_valid(flit_valid2),
    .flit_ready(ready2), .pkt_count(pkt_count2), .busy(busy2)
  );

  // Reference LFSR (taps 32,22 XNOR) and free-running cycle count for the default instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 32'h0000_0001;
      m_prev <= 32'h0000_0001;
      cyc    <= '0;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[30:0], ~(m_lfsr[31] ^ m_lfsr[21])};
      cyc    <= cyc + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head1(input string name, input logic [3:0] dx, input logic [3:0] dy,
                             input logic [7:0] pid);
`ifdef TRAFFIC_GEN_RAND_DEST_EN
    check(name, flit_out & 32'hFFFF_00FF, {2'b01, 22'b0, pid});
    check({name, "_range"}, {31'b0, (flit_out[11:8] < 4'd2) && (flit_out[15:12] < 4'd2) &&
                             (flit_out[15:8] != 8'h00)}, 32'd1);
`else
    check(name, flit_out, {2'b01, 14'b0, dy, dx, pid});
`endif
  endtask

  typedef struct {
    int          stall;
    bit          drop_en;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [7:0]  pid;
    logic [15:0] cnt;
  } pkt_vec_t;

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
  } dst_vec_t;

  pkt_vec_t vec[4];
  dst_vec_t dvec[8];

  initial begin
    int          waited;
    logic [15:0] ts;
    logic [31:0] held;
    bit          saw;
    int          n2;

    vec[0] = '{stall: 0, drop_en: 1'b0, dx: 4'd1, dy: 4'd0, pid: 8'd0, cnt: 16'd1};
    vec[1] = '{stall: 5, drop_en: 1'b0, dx: 4'd0, dy: 4'd1, pid: 8'd1, cnt: 16'd2};
    vec[2] = '{stall: 0, drop_en: 1'b1, dx: 4'd1, dy: 4'd1, pid: 8'd2, cnt: 16'd3};
    vec[3] = '{stall: 0, drop_en: 1'b0, dx: 4'd1, dy: 4'd0, pid: 8'd3, cnt: 16'd4};
    dvec[0] = '{dx: 4'd0, dy: 4'd0};
    dvec[1] = '{dx: 4'd1, dy: 4'd0};
    dvec[2] = '{dx: 4'd2, dy: 4'd0};
    dvec[3] = '{dx: 4'd3, dy: 4'd0};
    dvec[4] = '{dx: 4'd0, dy: 4'd1};
    dvec[5] = '{dx: 4'd2, dy: 4'd1};
    dvec[6] = '{dx: 4'd3, dy: 4'd1};
    dvec[7] = '{dx: 4'd0, dy: 4'd0};

    // Reset state
    repeat (3) tick();
    check("rst_valid", {31'b0, flit_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pkt_count", {16'b0, pkt_count}, 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_valid2", {31'b0, flit_valid2}, 32'd0);

    enable = 1'b1;
    flit_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Packet table: head at 101 cycles after release / IDLE entry, stall, enable drop, dests.
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!flit_valid && waited < 400) begin
        tick();
        waited++;
      end
      check("head_wait", waited, 32'd101);
      ts = cyc;
      check_head1("head", vec[i].dx, vec[i].dy, vec[i].pid);
      check("head_busy", {31'b0, busy}, 32'd1);
      tick();
      if (vec[i].drop_en) enable = 1'b0;
      check("body1", flit_out, {2'b00, m_prev[29:0]});
      if (vec[i].stall > 0) begin
        held = flit_out;
        flit_ready = 1'b0;
        for (int k = 0; k < vec[i].stall; k++) begin
          tick();
          check("stall_dat", flit_out, held);
          check("stall_vld", {31'b0, flit_valid}, 32'd1);
        end
        flit_ready = 1'b1;
      end
      tick();
      check("body2", flit_out, {2'b00, m_prev[29:0]});
      tick();
      check("tail", flit_out, {2'b10, ts, 6'b0, vec[i].pid});
      if (i == 0) check("tail0_hand", flit_out, 32'h8019_4000);
      tick();
      check("idle_valid", {31'b0, flit_valid}, 32'd0);
      check("pkt_count", {16'b0, pkt_count}, {16'b0, vec[i].cnt});
      if (vec[i].drop_en) begin
        saw = 1'b0;
        for (int k = 0; k < 150; k++) begin
          tick();
          if (flit_valid || busy) saw = 1'b1;
        end
        check("no_head_while_disabled", {31'b0, saw}, 32'd0);
        enable = 1'b1;
      end
    end

    // Reset while the tail is stalled: valid drops at once, restart with pid 0.
    waited = 0;
    while (!flit_valid && waited < 400) begin
      tick();
      waited++;
    end
    check_head1("head5", 4'd0, 4'd1, 8'd4);
    tick();
    tick();
    tick();
    flit_ready = 1'b0;
    tick();
    tick();
    check("tail_wait_type", {30'b0, flit_out[31:30]}, 32'd2);
    check("tail_wait_vld", {31'b0, flit_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {31'b0, flit_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_pkt_count", {16'b0, pkt_count}, 32'd0);
    check("arst_flit_out", flit_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    flit_ready = 1'b1;
    waited = 0;
    while (!flit_valid && waited < 400) begin
      tick();
      waited++;
    end
    check("head_wait_after_rst", waited, 32'd101);
    check_head1("head_after_rst", 4'd1, 4'd0, 8'd0);
    repeat (4) tick();
    check("pkt_count_after_rst", {16'b0, pkt_count}, 32'd1);
    enable = 1'b0;

    // Second instance: zero body flits, sequential walk skipping (1,1) or random dests.
`ifdef TRAFFIC_GEN_RAND_DEST_EN
    n2 = 1000;
`else
    n2 = 8;
`endif
    enable2 = 1'b1;
    for (int i = 0; i < n2; i++) begin
      waited = 0;
      while (!flit_valid2 && waited < 20) begin
        tick();
        waited++;
      end
`ifdef TRAFFIC_GEN_RAND_DEST_EN
      check("rand_dest_ok", {31'b0, (flit_out2[11:8] < 4'd4) && (flit_out2[15:12] < 4'd2) &&
                             (flit_out2[15:8] != 8'h11)}, 32'd1);
`else
      check("seq_head", flit_out2, {2'b01, 14'b0, dvec[i].dy, dvec[i].dx, 8'(i)});
`endif
      tick();
      check("zero_body_tail", {22'b0, flit_out2[31:30], flit_out2[7:0]}, {22'b0, 2'b10, 8'(i)});
      tick();
    end
    check("pkt_count2", {16'b0, pkt_count2}, 32'(n2));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_traffic_gen.md
NOC_TRAFFIC_GEN -- requirements
Module: noc_traffic_gen

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits (min 32).
REQ-002 SHALL have parameter MESH_X, default 2, mesh columns (power of 2, 2..16).
REQ-003 SHALL have parameter MESH_Y, default 2, mesh rows (power of 2, 2..16).
REQ-004 SHALL have parameters SRC_X and SRC_Y, default 0, own node coordinates.
REQ-005 SHALL have parameter BODY_FLITS, default 2, body flits per packet (0..255).
REQ-006 SHALL have parameter GAP, default 100, idle cycles between packets (1..65535).
REQ-007 SHALL have parameter SEED, default 32'h0000_0001, LFSR reset value.
REQ-008 SHALL have port clk, input, 1, single clock, rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port enable, input, 1, permits new packet starts.
REQ-011 SHALL have port flit_out, output, FLIT_W, flit data.
REQ-012 SHALL have port flit_valid, output, 1, flit_out holds a valid flit.
REQ-013 SHALL have port flit_ready, input, 1, downstream accepts the flit.
REQ-014 SHALL have port pkt_count, output, 16, number of tails accepted, wraps at 65535.
REQ-015 SHALL have port busy, output, 1, high in HEAD, BODY or TAIL.

Function
REQ-016 SHALL transfer a flit only on a cycle with flit_valid=1 and flit_ready=1.
REQ-017 SHALL keep flit_out stable while flit_valid=1 and flit_ready=0.
REQ-018 SHALL implement FSM IDLE -> HEAD -> BODY (BODY_FLITS times; skipped when 0) -> TAIL -> IDLE, advancing only on a transfer.
REQ-019 SHALL count GAP cycles in IDLE while enable=1, then enter HEAD on the next edge; gap counter clears on entering IDLE and holds while enable=0.
REQ-020 SHALL finish the current packet through TAIL when enable drops mid-packet.
REQ-021 SHALL format flit type in flit_out[FLIT_W-1:FLIT_W-2]: head 2'b01, body 2'b00, tail 2'b10.
REQ-022 SHALL format head bits [29:0]: [29:16] zero, [15:12] dst_y, [11:8] dst_x, [7:0] pid; higher bits up to type field zero.
REQ-023 SHALL format body bits [FLIT_W-3:0] as the low LFSR bits sampled on entry to that flit.
REQ-024 SHALL format tail bits [29:0]: [29:14] timestamp of head transfer (16-bit free-running cycle counter), [13:8] zero, [7:0] pid.
REQ-025 SHALL use a 32-bit Fibonacci XNOR LFSR, taps 32 and 22, advancing every cycle out of reset.
REQ-026 SHALL increment pid (8-bit, wraps 255->0) and pkt_count on each tail transfer.
REQ-027 SHALL default to sequential destinations: x increments, wraps to 0 at MESH_X and carries into y, y wraps at MESH_Y, skipping (SRC_X,SRC_Y); first destination is the first non-self node after (0,0) inclusive.
REQ-028 SHALL update the destination only on a tail transfer.

Reset
REQ-029 SHALL, on reset=0, asynchronously clear flit_out, flit_valid, busy, pkt_count, pid, gap counter, timestamp counter; set LFSR to SEED and FSM to IDLE.
REQ-030 SHALL abandon any in-flight packet on reset with no tail emitted; generation restarts with pid 0.

Configuration
REQ-031 SHALL, with macro TRAFFIC_GEN_RAND_DEST_EN defined, take dst_x = LFSR[3:0] mod MESH_X and dst_y = LFSR[7:4] mod MESH_Y at HEAD entry, inverting dst_x bit 0 if equal to own node.
REQ-032 SHALL, without TRAFFIC_GEN_RAND_DEST_EN, use sequential destinations per REQ-027.

Structure
REQ-033 SHALL place flit type constants, FSM state encoding and LFSR tap constants in shared package noc_tg_pkg.
REQ-034 SHALL implement the LFSR as sub-module lfsr_core (seed parameter, 32-bit state output).

Verification
REQ-035 SHALL cover: defaults, enable=1, flit_ready=1 -> head at cycle 101 after reset release, 4 flits head/body/body/tail, pid 0, dst (1,0).
REQ-036 SHALL cover: flit_ready=0 for 5 cycles mid-body -> flit_out and flit_valid unchanged; FSM holds.
REQ-037 SHALL cover: enable dropped after head transfer -> body, body, tail still emitted; no new head while enable=0.
REQ-038 SHALL cover: 4 packets sequential, MESH 2x2, SRC (0,0) -> destinations (1,0),(0,1),(1,1),(1,0); pkt_count=4.
REQ-039 SHALL cover: reset asserted during TAIL wait -> flit_valid=0 immediately; next head pid=0.
REQ-040 SHALL cover: TRAFFIC_GEN_RAND_DEST_EN, 1000 packets -> no destination equals (SRC_X,SRC_Y); all coordinates in range.
